// File: rtl/cp0_exception_unit_pkg.sv
// Shared definitions for the CP0 exception unit: register numbers, ExcCodes,
// Status/Cause bit positions, write masks and the pipeline exception vector type.
package cp0_exception_unit_pkg;

    // Redirect target and Status reset value (BEV=1)
    localparam logic [31:0] EXC_VECTOR_DFLT = 32'hBFC0_0380;
    localparam logic [31:0] STATUS_RST_DFLT = 32'h0040_0000;

    // CP0 register numbers
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // Exception codes written into Cause.ExcCode
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    // Status / Cause bit positions
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;

    // Software-writable bits for MTC0
    localparam logic [31:0] STATUS_WR_MASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WR_MASK  = 32'h0000_0300;

    // Exception vector carried down the pipeline, bit8 .. bit0
    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic ReservedInstruction;
        logic Overflow;
        logic Syscall;
        logic Break;
        logic Eret;
        logic WrWrongAddressinMEM;
        logic RdWrongAddressinMEM;
    } ExceptinPipeType;

    // Level-sensitive hardware interrupt lines
    typedef logic [5:0] AsynExceptType;

    // Merge a write into a register, touching only the bits set in mask
    function automatic logic [31:0] mask_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Bus between the pipeline (master) and the CP0 exception unit (slave).
interface cp0_exception_unit_if;
    import cp0_exception_unit_pkg::*;

    ExceptinPipeType MEM_ExceptType;
    logic            MEM_IsDelaySlot;
    logic [31:0]     MEM_PC;
    logic [31:0]     MEM_ALUOut;
    AsynExceptType   Ext_Int;
    logic [4:0]      CP0_RdAddr;
    logic [31:0]     CP0_RdData;
    logic            CP0_Wr;
    logic [4:0]      CP0_WrAddr;
    logic [31:0]     CP0_WrData;
    logic            Exc_Flush;
    logic [31:0]     Exc_NPC;
    logic            Int_Pending;
    logic [31:0]     CP0_EPC;

    modport master (
        output MEM_ExceptType, MEM_IsDelaySlot, MEM_PC, MEM_ALUOut, Ext_Int,
               CP0_RdAddr, CP0_Wr, CP0_WrAddr, CP0_WrData,
        input  CP0_RdData, Exc_Flush, Exc_NPC, Int_Pending, CP0_EPC
    );

    modport slave (
        input  MEM_ExceptType, MEM_IsDelaySlot, MEM_PC, MEM_ALUOut, Ext_Int,
               CP0_RdAddr, CP0_Wr, CP0_WrAddr, CP0_WrData,
        output CP0_RdData, Exc_Flush, Exc_NPC, Int_Pending, CP0_EPC
    );

endinterface

// File: rtl/cp0_exception_unit_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, TI latches on a
// Count==Compare match and is cleared by any write to Compare.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_wr,
    input  logic        compare_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        tick_q, tick_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    // Next-state: software writes beat the increment; Compare write beats a match
    always_comb begin
        tick_d    = ~tick_q;
        count_d   = count_q;
        compare_d = compare_q;
        ti_d      = ti_q;
        if (count_wr) begin
            count_d = wr_data;
        end else if (tick_q) begin
            count_d = count_q + 32'd1;
        end
        if (compare_wr) begin
            compare_d = wr_data;
        end
        if (tick_q && (count_q == compare_q)) begin
            ti_d = 1'b1;
        end
        if (compare_wr) begin
            ti_d = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_q    <= 1'b0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            ti_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 exception unit: resolves MEM-stage exception priority, updates
// BadVAddr/Status/Cause/EPC, drives flush/redirect, serves MFC0/MTC0 and
// raises the interrupt-pending request for ID.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
    parameter logic [31:0] STATUS_RST = STATUS_RST_DFLT
) (
    input logic                 clk,
    input logic                 rst,
    cp0_exception_unit_if.slave bus
);

    ExceptinPipeType et;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] count, compare;
    logic        ti;
    logic        wr_count, wr_compare, wr_status, wr_cause;
    logic        exc_taken, eret_only, bad_upd;
    logic [4:0]  exc_code;
    logic [31:0] bad_val;

    assign et         = bus.MEM_ExceptType;
    assign wr_count   = bus.CP0_Wr && (bus.CP0_WrAddr == REG_COUNT);
    assign wr_compare = bus.CP0_Wr && (bus.CP0_WrAddr == REG_COMPARE);
    assign wr_status  = bus.CP0_Wr && (bus.CP0_WrAddr == REG_STATUS);
    assign wr_cause   = bus.CP0_Wr && (bus.CP0_WrAddr == REG_CAUSE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_wr   (wr_count),
        .compare_wr (wr_compare),
        .wr_data    (bus.CP0_WrData),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // Priority encoder: first asserted non-Eret exception picks ExcCode/BadVAddr
    always_comb begin
        exc_taken = 1'b1;
        exc_code  = EXC_INT;
        bad_upd   = 1'b0;
        bad_val   = bus.MEM_ALUOut;
        if (et.Interrupt) begin
            exc_code = EXC_INT;
        end else if (et.WrongAddressinIF) begin
            exc_code = EXC_ADEL;
            bad_upd  = 1'b1;
            bad_val  = bus.MEM_PC;
        end else if (et.ReservedInstruction) begin
            exc_code = EXC_RI;
        end else if (et.Overflow) begin
            exc_code = EXC_OV;
        end else if (et.Syscall) begin
            exc_code = EXC_SYS;
        end else if (et.Break) begin
            exc_code = EXC_BP;
        end else if (et.RdWrongAddressinMEM) begin
            exc_code = EXC_ADEL;
            bad_upd  = 1'b1;
        end else if (et.WrWrongAddressinMEM) begin
            exc_code = EXC_ADES;
            bad_upd  = 1'b1;
        end else begin
            exc_taken = 1'b0;
        end
    end

    assign eret_only = et.Eret && !exc_taken;

    // Register next-state: MTC0 first, then exception/Eret field overrides
    always_comb begin
        badvaddr_d = badvaddr_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;

        cause_d[15:10] = {bus.Ext_Int[5] | ti, bus.Ext_Int[4:0]};

        if (wr_status) begin
            status_d = mask_merge(status_q, bus.CP0_WrData, STATUS_WR_MASK);
        end
        if (wr_cause) begin
            cause_d = mask_merge(cause_d, bus.CP0_WrData, CAUSE_WR_MASK);
        end

        if (exc_taken) begin
            status_d[STATUS_EXL] = 1'b1;
            cause_d[6:2]         = exc_code;
            if (bad_upd) begin
                badvaddr_d = bad_val;
            end
            // A nested exception keeps the EPC/BD of the original one
            if (!status_q[STATUS_EXL]) begin
                epc_d             = bus.MEM_IsDelaySlot ? bus.MEM_PC - 32'd4 : bus.MEM_PC;
                cause_d[CAUSE_BD] = bus.MEM_IsDelaySlot;
            end
        end else if (eret_only) begin
            status_d[STATUS_EXL] = 1'b0;
        end
    end

    // CP0 architectural registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr_q <= 32'd0;
            status_q   <= STATUS_RST;
            cause_q    <= 32'd0;
            epc_q      <= 32'd0;
        end else begin
            badvaddr_q <= badvaddr_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
        end
    end

    // MFC0 read mux; TI is held in the timer and folded into Cause here
    always_comb begin
        bus.CP0_RdData = 32'd0;
        case (bus.CP0_RdAddr)
            REG_BADVADDR: bus.CP0_RdData = badvaddr_q;
            REG_COUNT:    bus.CP0_RdData = count;
            REG_COMPARE:  bus.CP0_RdData = compare;
            REG_STATUS:   bus.CP0_RdData = status_q;
            REG_CAUSE:    bus.CP0_RdData = cause_q | (32'(ti) << CAUSE_TI);
            REG_EPC:      bus.CP0_RdData = epc_q;
            default:      bus.CP0_RdData = 32'd0;
        endcase
    end

    // Flush/redirect are combinational but forced off while reset is held
    assign bus.Exc_Flush   = rst && (exc_taken || eret_only);
    assign bus.Exc_NPC     = !rst      ? 32'd0 :
                             exc_taken ? EXC_VECTOR :
                             eret_only ? epc_q : 32'd0;
    assign bus.Int_Pending = status_q[STATUS_IE] && !status_q[STATUS_EXL] &&
                             (|(cause_q[15:8] & status_q[15:8]));
    assign bus.CP0_EPC     = epc_q;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: reset, exception priority, EPC/BD
// handling, Eret, MTC0 masks, timer interrupt and asynchronous reset.
module tb_cp0_exception_unit;
    import cp0_exception_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    cp0_exception_unit_if bus ();

    cp0_exception_unit dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus.CP0_RdAddr = a;
        #1;
        v = bus.CP0_RdData;
        chk(tag, v, exp);
    endtask

    task automatic idle_inputs();
        bus.MEM_ExceptType  = '0;
        bus.MEM_IsDelaySlot = 1'b0;
        bus.MEM_PC          = 32'd0;
        bus.MEM_ALUOut      = 32'd0;
        bus.CP0_Wr          = 1'b0;
        bus.CP0_WrAddr      = 5'd0;
        bus.CP0_WrData      = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.CP0_Wr     = 1'b1;
        bus.CP0_WrAddr = a;
        bus.CP0_WrData = d;
        tick();
        bus.CP0_Wr     = 1'b0;
        $display("mtc0 reg=%0d data=%h", a, d);
    endtask

    initial begin
        logic found;
        rst_n = 1'b0;
        bus.Ext_Int    = '0;
        bus.CP0_RdAddr = 5'd0;
        idle_inputs();
        tick();
        tick();

        // Reset state, with an exception presented while reset is held
        bus.MEM_ExceptType.Overflow = 1'b1;
        #1;
        chk("rst_flush", 32'(bus.Exc_Flush), 32'd0);
        chk("rst_npc", bus.Exc_NPC, 32'd0);
        chk("rst_intpend", 32'(bus.Int_Pending), 32'd0);
        idle_inputs();
        chk_reg("rst_status", REG_STATUS, 32'h0040_0000);
        chk_reg("rst_count", REG_COUNT, 32'd0);
        chk_reg("rst_cause", REG_CAUSE, 32'd0);
        rst_n = 1'b1;

        // Ten idle cycles -> Count advances every second clock
        repeat (10) tick();
        $display("step: idle 10 cycles after reset");
        chk_reg("idle_count", REG_COUNT, 32'd5);
        chk_reg("idle_status", REG_STATUS, 32'h0040_0000);
        chk("idle_flush", 32'(bus.Exc_Flush), 32'd0);

        // Park Compare far away (also clears any TI) and let IP settle
        mtc0(REG_COMPARE, 32'h0000_1000);
        tick();
        chk_reg("compare_rd", REG_COMPARE, 32'h0000_1000);
        chk_reg("cause_clean", REG_CAUSE, 32'd0);

        // Overflow in a delay slot
        $display("step: overflow in delay slot");
        bus.MEM_ExceptType.Overflow = 1'b1;
        bus.MEM_PC          = 32'hBFC0_0100;
        bus.MEM_IsDelaySlot = 1'b1;
        #1;
        chk("ov_flush", 32'(bus.Exc_Flush), 32'd1);
        chk("ov_npc", bus.Exc_NPC, 32'hBFC0_0380);
        tick();
        idle_inputs();
        chk_reg("ov_epc", REG_EPC, 32'hBFC0_00FC);
        chk("ov_epc_port", bus.CP0_EPC, 32'hBFC0_00FC);
        chk_reg("ov_cause", REG_CAUSE, 32'h8000_0030);
        chk_reg("ov_status", REG_STATUS, 32'h0040_0002);

        // Overflow beats WrWrongAddress; nested, so EPC/BD untouched
        $display("step: overflow + store address error");
        bus.MEM_ExceptType.Overflow            = 1'b1;
        bus.MEM_ExceptType.WrWrongAddressinMEM = 1'b1;
        bus.MEM_ALUOut = 32'h8000_0003;
        bus.MEM_PC     = 32'h9000_0000;
        #1;
        chk("ovw_npc", bus.Exc_NPC, 32'hBFC0_0380);
        tick();
        idle_inputs();
        chk_reg("ovw_cause", REG_CAUSE, 32'h8000_0030);
        chk_reg("ovw_badvaddr", REG_BADVADDR, 32'd0);
        chk_reg("ovw_epc", REG_EPC, 32'hBFC0_00FC);

        // Eret returns to EPC and clears EXL
        $display("step: eret");
        bus.MEM_ExceptType.Eret = 1'b1;
        #1;
        chk("eret1_flush", 32'(bus.Exc_Flush), 32'd1);
        chk("eret1_npc", bus.Exc_NPC, 32'hBFC0_00FC);
        tick();
        idle_inputs();
        chk_reg("eret1_status", REG_STATUS, 32'h0040_0000);

        // Syscall outside a delay slot
        $display("step: syscall");
        bus.MEM_ExceptType.Syscall = 1'b1;
        bus.MEM_PC = 32'h8000_1000;
        #1;
        chk("sys_npc", bus.Exc_NPC, 32'hBFC0_0380);
        tick();
        idle_inputs();
        chk_reg("sys_epc", REG_EPC, 32'h8000_1000);
        chk_reg("sys_cause", REG_CAUSE, 32'h0000_0020);
        chk_reg("sys_status", REG_STATUS, 32'h0040_0002);

        // Eret with a same-cycle MTC0 to EPC, which is ignored
        $display("step: eret with mtc0 epc");
        bus.MEM_ExceptType.Eret = 1'b1;
        bus.CP0_Wr     = 1'b1;
        bus.CP0_WrAddr = REG_EPC;
        bus.CP0_WrData = 32'h1234_5678;
        #1;
        chk("eret2_npc", bus.Exc_NPC, 32'h8000_1000);
        tick();
        idle_inputs();
        chk_reg("eret2_epc", REG_EPC, 32'h8000_1000);
        chk_reg("eret2_status", REG_STATUS, 32'h0040_0000);

        // Load address error in delay slot with a same-cycle MTC0 Cause
        $display("step: load address error + mtc0 cause");
        bus.MEM_ExceptType.RdWrongAddressinMEM = 1'b1;
        bus.MEM_ALUOut      = 32'h0000_1001;
        bus.MEM_PC          = 32'h8000_2000;
        bus.MEM_IsDelaySlot = 1'b1;
        bus.CP0_Wr     = 1'b1;
        bus.CP0_WrAddr = REG_CAUSE;
        bus.CP0_WrData = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        chk_reg("adel_cause", REG_CAUSE, 32'h8000_0310);
        chk_reg("adel_badvaddr", REG_BADVADDR, 32'h0000_1001);
        chk_reg("adel_epc", REG_EPC, 32'h8000_1FFC);

        // Interrupt beats fetch address error and Eret; EXL stays set
        $display("step: interrupt + fetch error + eret");
        bus.MEM_ExceptType.Interrupt        = 1'b1;
        bus.MEM_ExceptType.WrongAddressinIF = 1'b1;
        bus.MEM_ExceptType.Eret             = 1'b1;
        bus.MEM_PC = 32'hA000_0004;
        #1;
        chk("int_npc", bus.Exc_NPC, 32'hBFC0_0380);
        tick();
        idle_inputs();
        chk_reg("int_cause", REG_CAUSE, 32'h8000_0300);
        chk_reg("int_status", REG_STATUS, 32'h0040_0002);
        chk_reg("int_badvaddr", REG_BADVADDR, 32'h0000_1001);
        chk_reg("int_epc", REG_EPC, 32'h8000_1FFC);

        // Leave EXL, then fetch address error alone
        bus.MEM_ExceptType.Eret = 1'b1;
        tick();
        idle_inputs();
        $display("step: fetch address error");
        bus.MEM_ExceptType.WrongAddressinIF = 1'b1;
        bus.MEM_PC = 32'hA000_0004;
        tick();
        idle_inputs();
        chk_reg("adif_badvaddr", REG_BADVADDR, 32'hA000_0004);
        chk_reg("adif_epc", REG_EPC, 32'hA000_0004);
        chk_reg("adif_cause", REG_CAUSE, 32'h0000_0310);

        // Eret with Cause cleared, then RI beats Syscall and Break
        bus.MEM_ExceptType.Eret = 1'b1;
        bus.CP0_Wr     = 1'b1;
        bus.CP0_WrAddr = REG_CAUSE;
        bus.CP0_WrData = 32'd0;
        tick();
        idle_inputs();
        $display("step: reserved instruction + syscall + break");
        bus.MEM_ExceptType.ReservedInstruction = 1'b1;
        bus.MEM_ExceptType.Syscall             = 1'b1;
        bus.MEM_ExceptType.Break               = 1'b1;
        bus.MEM_PC = 32'h8000_3000;
        tick();
        idle_inputs();
        chk_reg("ri_cause", REG_CAUSE, 32'h0000_0028);
        chk_reg("ri_epc", REG_EPC, 32'h8000_3000);
        bus.MEM_ExceptType.Eret = 1'b1;
        tick();
        idle_inputs();

        // No exception; MTC0 to BadVAddr is ignored
        $display("step: mtc0 badvaddr ignored");
        bus.CP0_Wr     = 1'b1;
        bus.CP0_WrAddr = REG_BADVADDR;
        bus.CP0_WrData = 32'h0000_FFFF;
        #1;
        chk("noexc_flush", 32'(bus.Exc_Flush), 32'd0);
        tick();
        idle_inputs();
        chk_reg("noexc_badvaddr", REG_BADVADDR, 32'hA000_0004);

        // Timer interrupt
        $display("step: timer interrupt");
        mtc0(REG_STATUS, 32'h0000_8001);
        chk_reg("tmr_status", REG_STATUS, 32'h0040_8001);
        mtc0(REG_COMPARE, 32'd4);
        mtc0(REG_COUNT, 32'd0);
        #1;
        chk("tmr_intpend0", 32'(bus.Int_Pending), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            bus.CP0_RdAddr = REG_CAUSE;
            #1;
            if (bus.CP0_RdData[CAUSE_TI]) found = 1'b1;
            else tick();
        end
        chk("tmr_ti_rise", 32'(found), 32'd1);
        chk_reg("tmr_count_at_ti", REG_COUNT, 32'd5);
        tick();
        chk("tmr_intpend1", 32'(bus.Int_Pending), 32'd1);
        mtc0(REG_COMPARE, 32'h0000_0100);
        chk_reg("tmr_cause_clr", REG_CAUSE, 32'h0000_8028);
        chk("tmr_intpend_lag", 32'(bus.Int_Pending), 32'd1);
        tick();
        chk("tmr_intpend_off", 32'(bus.Int_Pending), 32'd0);
        chk_reg("tmr_cause_off", REG_CAUSE, 32'h0000_0028);

        // Status write mask and EXL masking of interrupts
        $display("step: status mask and exl masking");
        mtc0(REG_STATUS, 32'hFFFF_FFFF);
        chk_reg("msk_status", REG_STATUS, 32'h0040_FF03);
        bus.Ext_Int = 6'h3F;
        tick();
        chk("msk_intpend_exl", 32'(bus.Int_Pending), 32'd0);
        chk_reg("msk_cause_ip", REG_CAUSE, 32'h0000_FC28);
        mtc0(REG_STATUS, 32'h0000_FF01);
        chk("msk_intpend_on", 32'(bus.Int_Pending), 32'd1);

        // Asynchronous reset in the middle of an exception
        $display("step: asynchronous reset");
        bus.MEM_ExceptType.Overflow = 1'b1;
        bus.MEM_PC = 32'h8000_4000;
        #1;
        chk("arst_flush_pre", 32'(bus.Exc_Flush), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(bus.Exc_Flush), 32'd0);
        chk("arst_npc", bus.Exc_NPC, 32'd0);
        chk("arst_intpend", 32'(bus.Int_Pending), 32'd0);
        chk_reg("arst_status", REG_STATUS, 32'h0040_0000);
        chk_reg("arst_count", REG_COUNT, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
